// File: rtl/event_token_source_pkg.sv
// +-----------------------------------------------------------------------------+
// | event_token_source_pkg                                                      |
// | Shared limits and parameter checks for the event token source.              |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package event_token_source_pkg;

   localparam int c_CNT_W_MIN = 2;
   localparam int c_CNT_W_MAX = 16;

   // Legal when the counter width is in range and a single cycle's events fit in it.
   function automatic bit params_ok(input int cnt_w, input int evt_w);
      return (cnt_w >= c_CNT_W_MIN) && (cnt_w <= c_CNT_W_MAX) &&
             (evt_w >= 1) && (evt_w <= cnt_w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/event_token_source_sat_add_dec.sv
// +-----------------------------------------------------------------------------+
// | sat_add_dec                                                                 |
// | Combinational saturating add-and-decrement for token/credit counters.       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sat_add_dec #(
   parameter int CNT_W = 8,
   parameter int EVT_W = 2
) (
   input  logic [CNT_W-1:0] cnt_i,
   input  logic [EVT_W-1:0] evt_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_next_o,
   output logic             ovf_hit_o
);

   logic [CNT_W:0] w_sum;

   // One extra bit holds the worst case (max + max event count), so the MSB
   // alone flags anything above the counter limit. Callers keep dec_i low at zero.
   assign w_sum      = {1'b0, cnt_i} + (CNT_W+1)'(evt_i) - (CNT_W+1)'(dec_i);
   assign ovf_hit_o  = w_sum[CNT_W];
   assign cnt_next_o = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/event_token_source.sv
// +-----------------------------------------------------------------------------+
// | event_token_source                                                          |
// | Saturating pending-event counter draining one token/cycle into a FIFO.      |
// | Optional sticky overflow flag: define BSV_EVENT_OVF_FLAG_EN.                |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module event_token_source
   import event_token_source_pkg::*;
#(
   parameter int cntWidth = 8,
   parameter int evtWidth = 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [evtWidth-1:0] EVT_N,
   output logic                ENQ,
   input  logic                FULL_N,
   output logic [cntWidth-1:0] PENDING,
   output logic                OVF,
   input  logic                OVF_CLR
);

`ifndef BSV_NO_PARAM_CHECKS
   generate
      if (!params_ok(cntWidth, evtWidth)) begin : g_bad_params
         $fatal(1, "event_token_source: need 2<=cntWidth<=16 and evtWidth<=cntWidth");
      end
   endgenerate
`endif

   logic [cntWidth-1:0] cnt_q;
   logic [cntWidth-1:0] cnt_d;
   logic                w_ovf_hit;

   // Never looks at EVT_N: a fresh event waits at least one cycle in the counter.
   assign ENQ     = FULL_N & (cnt_q != '0) & ~RST;
   assign PENDING = cnt_q;

   sat_add_dec #(
      .CNT_W (cntWidth),
      .EVT_W (evtWidth)
   ) u_sat_add_dec (
      .cnt_i      (cnt_q),
      .evt_i      (EVT_N),
      .dec_i      (ENQ),
      .cnt_next_o (cnt_d),
      .ovf_hit_o  (w_ovf_hit)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifdef BSV_EVENT_OVF_FLAG_EN
   logic ovf_q;
   logic ovf_d;

   // Set beats clear so a coincident overflow is never hidden.
   assign ovf_d = w_ovf_hit | (ovf_q & ~OVF_CLR);

   always_ff @(posedge CLK) begin
      if (RST) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign OVF = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = OVF_CLR | w_ovf_hit;
   assign OVF        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_event_token_source.sv
// +-----------------------------------------------------------------------------+
// | tb_event_token_source                                                       |
// | Vector table plus scoreboarded sequences for event_token_source (cntWidth=4)|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_event_token_source;

   localparam int c_CW   = 4;
   localparam int c_EW   = 2;
   localparam int c_MAXC = 15;
`ifdef BSV_EVENT_OVF_FLAG_EN
   localparam bit c_OVF_EN = 1'b1;
`else
   localparam bit c_OVF_EN = 1'b0;
`endif

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic [c_EW-1:0] EVT_N = '0;
   logic            FULL_N = 1'b1;
   logic            OVF_CLR = 1'b0;
   logic            ENQ;
   logic            OVF;
   logic [c_CW-1:0] PENDING;

   int   n_vec  = 0;
   int   n_fail = 0;
   int   enq_seen = 0;

   typedef struct {
      logic rst;
      int   evt;
      logic full;
      logic clr;
      logic enq;
      int   pend;
      logic ovf;
   } vec_t;

   typedef struct {
      logic enq;
      int   pend;
      logic ovf;
   } exp_t;

   exp_t sbq[$];
   int   m_cnt = 0;
   logic m_ovf = 1'b0;

   event_token_source #(
      .cntWidth (c_CW),
      .evtWidth (c_EW)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EVT_N   (EVT_N),
      .ENQ     (ENQ),
      .FULL_N  (FULL_N),
      .PENDING (PENDING),
      .OVF     (OVF),
      .OVF_CLR (OVF_CLR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs, queue its expectations, compare on the falling edge.
   task automatic drive(input logic rst, input int evt, input logic full, input logic clr,
                        input logic e_enq, input int e_pend, input logic e_ovf, input string tag);
      exp_t e;
      RST     = rst;
      EVT_N   = c_EW'(evt);
      FULL_N  = full;
      OVF_CLR = clr;
      sbq.push_back('{enq: e_enq, pend: e_pend, ovf: e_ovf});
      @(negedge CLK);
      e = sbq.pop_front();
      check({tag, ".enq"},     32'(ENQ),     32'(e.enq));
      check({tag, ".pending"}, 32'(PENDING), 32'(e.pend));
      check({tag, ".ovf"},     32'(OVF),     32'(e.ovf));
      enq_seen += (ENQ === 1'b1) ? 1 : 0;
      @(posedge CLK);
      #1;
   endtask

   task automatic mstep(input logic rst, input int evt, input logic full, input logic clr,
                        input string tag);
      logic e_enq;
      int   nxt;
      bit   hit;
      e_enq = !rst && full && (m_cnt != 0);
      drive(rst, evt, full, clr, e_enq, m_cnt, m_ovf, tag);
      if (rst) begin
         m_cnt = 0;
         m_ovf = 1'b0;
      end else begin
         nxt   = m_cnt + evt - (e_enq ? 1 : 0);
         hit   = (nxt > c_MAXC);
         m_cnt = hit ? c_MAXC : nxt;
         if (c_OVF_EN) m_ovf = hit ? 1'b1 : (clr ? 1'b0 : m_ovf);
      end
   endtask

   initial begin
      vec_t vt[8];
      vt[0] = '{1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0};
      vt[1] = '{1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0};
      vt[2] = '{1'b1, 3, 1'b1, 1'b0, 1'b0, 0, 1'b0};
      vt[3] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
      vt[4] = '{1'b0, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0};
      vt[5] = '{1'b0, 0, 1'b1, 1'b0, 1'b1, 1, 1'b0};
      vt[6] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
      vt[7] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0};

      RST = 1'b1; EVT_N = 2'd3; FULL_N = 1'b1;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 8; i++)
         drive(vt[i].rst, vt[i].evt, vt[i].full, vt[i].clr,
               vt[i].enq, vt[i].pend, vt[i].ovf, $sformatf("vec%0d", i));
      m_cnt = 0;
      m_ovf = 1'b0;

      // Backpressure: 4 x 3 events held, then exactly 12 tokens drained.
      repeat (4) mstep(1'b0, 3, 1'b0, 1'b0, "bp_fill");
      check("bp_pending", 32'(PENDING), 32'd12);
      check("bp_enq_low", 32'(ENQ), 32'd0);
      enq_seen = 0;
      repeat (14) mstep(1'b0, 0, 1'b1, 1'b0, "bp_drain");
      check("bp_enq_count", 32'(enq_seen), 32'd12);
      check("bp_empty", 32'(PENDING), 32'd0);

      // Simultaneous event and enqueue net out.
      mstep(1'b0, 3, 1'b0, 1'b0, "sim_fill");
      mstep(1'b0, 2, 1'b0, 1'b0, "sim_fill");
      check("sim_pending5", 32'(PENDING), 32'd5);
      enq_seen = 0;
      repeat (10) mstep(1'b0, 1, 1'b1, 1'b0, "sim_hold");
      check("sim_enq_count", 32'(enq_seen), 32'd10);
      check("sim_still5", 32'(PENDING), 32'd5);
      repeat (6) mstep(1'b0, 0, 1'b1, 1'b0, "sim_drain");

      // Saturation, then overflow set/clear interaction.
      repeat (5) mstep(1'b0, 3, 1'b0, 1'b0, "sat_fill");
      check("sat_at15_no_ovf", 32'(OVF), 32'd0);
      mstep(1'b0, 3, 1'b0, 1'b0, "sat_over");
      check("sat_pending", 32'(PENDING), 32'd15);
      check("sat_ovf", 32'(OVF), 32'(c_OVF_EN));
      mstep(1'b0, 3, 1'b0, 1'b1, "sat_set_vs_clr");
      check("sat_ovf_kept", 32'(OVF), 32'(c_OVF_EN));
      check("sat_still15", 32'(PENDING), 32'd15);
      mstep(1'b0, 0, 1'b1, 1'b1, "clr_pulse");
      check("clr_ovf", 32'(OVF), 32'd0);
      check("clr_pending14", 32'(PENDING), 32'd14);
      repeat (14) mstep(1'b0, 0, 1'b1, 1'b0, "clr_drain");
      check("clr_empty", 32'(PENDING), 32'd0);
      mstep(1'b0, 0, 1'b1, 1'b0, "idle");

      // Reset in mid-operation discards pending tokens.
      repeat (3) mstep(1'b0, 3, 1'b0, 1'b0, "mid_fill");
      mstep(1'b1, 3, 1'b1, 1'b0, "mid_rst");
      check("mid_rst_pending", 32'(PENDING), 32'd0);
      mstep(1'b0, 0, 1'b1, 1'b0, "mid_after");

      // Random traffic against the model.
      for (int k = 0; k < 60; k++)
         mstep(($urandom_range(0, 19) == 0), $urandom_range(0, 3),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0), "rand");

      check("sb_empty", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
